// File: rtl/aes_pkg.sv
// Shared AES datapath constants, byte indexing helper and feeder FSM encoding.
//   WORD_SIZE  : column width in bits
//   BYTE_SIZE  : byte width in bits
//   STATE_SIZE : AES state width (4 columns)
//   get_byte   : byte k of a column-major state (row k%4, column k/4), byte 0 in the MSBs
//   fsm_state_e: column feeder states
package aes_pkg;

    localparam int unsigned WORD_SIZE  = 32;
    localparam int unsigned BYTE_SIZE  = 8;
    localparam int unsigned STATE_SIZE = 4 * WORD_SIZE;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } fsm_state_e;

    function automatic logic [BYTE_SIZE-1:0] get_byte(
        input logic [STATE_SIZE-1:0] s,
        input int unsigned           k
    );
        return s[STATE_SIZE-1-BYTE_SIZE*k -: BYTE_SIZE];
    endfunction

endpackage

// File: rtl/shift_rows_sel.sv
// ShiftRows column selector: purely combinational.
//   state   : column-major AES state
//   col_idx : output column index c (0..3)
//   column  : {s[0][c], s[1][c+1], s[2][c+2], s[3][c+3]} (indices mod 4), row 0 in the MSBs
module shift_rows_sel #(
    parameter int unsigned WORD_SIZE  = aes_pkg::WORD_SIZE,
    parameter int unsigned BYTE_SIZE  = aes_pkg::BYTE_SIZE,
    parameter int unsigned STATE_SIZE = aes_pkg::STATE_SIZE
) (
    input  logic [STATE_SIZE-1:0] state,
    input  logic [1:0]            col_idx,
    output logic [WORD_SIZE-1:0]  column
);
    import aes_pkg::get_byte;

    // Row r takes its byte from column (c + r) mod 4; the 2-bit add wraps naturally.
    always_comb begin
        column = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            column[WORD_SIZE-1-BYTE_SIZE*r -: BYTE_SIZE] =
                get_byte(state, 32'(2'(col_idx + 2'(r))) * 4 + r);
        end
    end

endmodule

// File: rtl/shift_rows_col_feeder.sv
// ShiftRows column feeder: holds one post-SubBytes state and emits its four
// ShiftRows'd columns, one per non-stalled cycle, through registered outputs.
// A new state may be accepted while column 3 is selected, giving back-to-back
// streaming at one state per 4 cycles.
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   in_valid/ready  : state handshake (in_ready is combinational)
//   in_state        : column-major state, byte 0 in the MSBs
//   in_last_round   : state belongs to the final round
//   out_stall       : pause column emission
//   out_col_valid   : out_column valid
//   out_column      : ShiftRows'd column, row 0 in the MSBs
//   out_col_last    : emitted column is column 3
//   out_last_round  : last-round flag of the state being emitted
//   out_col_idx     : column index of out_column (only with SHIFT_ROWS_COL_IDX_EN)
// Build option: define SHIFT_ROWS_COL_IDX_EN to add the out_col_idx output.
module shift_rows_col_feeder #(
    parameter int unsigned WORD_SIZE  = aes_pkg::WORD_SIZE,
    parameter int unsigned BYTE_SIZE  = aes_pkg::BYTE_SIZE,
    parameter int unsigned STATE_SIZE = aes_pkg::STATE_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [STATE_SIZE-1:0] in_state,
    input  logic                  in_last_round,
    input  logic                  out_stall,
    output logic                  out_col_valid,
    output logic [WORD_SIZE-1:0]  out_column,
    output logic                  out_col_last,
`ifdef SHIFT_ROWS_COL_IDX_EN
    output logic [1:0]            out_col_idx,
`endif
    output logic                  out_last_round
);
    import aes_pkg::fsm_state_e;
    import aes_pkg::ST_IDLE;
    import aes_pkg::ST_SEND;

    fsm_state_e            state_q, state_d;
    logic [1:0]            col_cnt_q, col_cnt_d;
    logic [STATE_SIZE-1:0] hold_state_q, hold_state_d;
    logic                  hold_last_q, hold_last_d;
    logic                  out_col_valid_q, out_col_valid_d;
    logic [WORD_SIZE-1:0]  out_column_q, out_column_d;
    logic                  out_col_last_q, out_col_last_d;
    logic                  out_last_round_q, out_last_round_d;
    logic [1:0]            out_col_idx_q, out_col_idx_d;
    logic [WORD_SIZE-1:0]  sel_column;
    logic                  ready_c;
    logic                  emit_c;

    shift_rows_sel #(
        .WORD_SIZE  (WORD_SIZE),
        .BYTE_SIZE  (BYTE_SIZE),
        .STATE_SIZE (STATE_SIZE)
    ) u_sel (
        .state   (hold_state_q),
        .col_idx (col_cnt_q),
        .column  (sel_column)
    );

    // Next-state, handshake and output-register inputs.
    always_comb begin
        state_d          = state_q;
        col_cnt_d        = col_cnt_q;
        hold_state_d     = hold_state_q;
        hold_last_d      = hold_last_q;
        out_column_d     = out_column_q;
        out_last_round_d = out_last_round_q;
        out_col_idx_d    = out_col_idx_q;
        ready_c          = 1'b0;
        emit_c           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    hold_state_d = in_state;
                    hold_last_d  = in_last_round;
                    col_cnt_d    = 2'd0;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!out_stall) begin
                    emit_c    = 1'b1;
                    col_cnt_d = 2'(col_cnt_q + 2'd1);
                    // Column 3 leaves from the old hold value while a new state loads.
                    if (col_cnt_q == 2'd3) begin
                        ready_c = 1'b1;
                        if (in_valid) begin
                            hold_state_d = in_state;
                            hold_last_d  = in_last_round;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        out_col_valid_d = emit_c;
        out_col_last_d  = emit_c && (col_cnt_q == 2'd3);
        if (emit_c) begin
            out_column_d     = sel_column;
            out_last_round_d = hold_last_q;
            out_col_idx_d    = col_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            col_cnt_q        <= 2'd0;
            hold_state_q     <= '0;
            hold_last_q      <= 1'b0;
            out_col_valid_q  <= 1'b0;
            out_column_q     <= '0;
            out_col_last_q   <= 1'b0;
            out_last_round_q <= 1'b0;
            out_col_idx_q    <= 2'd0;
        end else begin
            state_q          <= state_d;
            col_cnt_q        <= col_cnt_d;
            hold_state_q     <= hold_state_d;
            hold_last_q      <= hold_last_d;
            out_col_valid_q  <= out_col_valid_d;
            out_column_q     <= out_column_d;
            out_col_last_q   <= out_col_last_d;
            out_last_round_q <= out_last_round_d;
            out_col_idx_q    <= out_col_idx_d;
        end
    end

    // in_ready is held low while reset is applied.
    assign in_ready       = ready_c && !reset;
    assign out_col_valid  = out_col_valid_q;
    assign out_column     = out_column_q;
    assign out_col_last   = out_col_last_q;
    assign out_last_round = out_last_round_q;
`ifdef SHIFT_ROWS_COL_IDX_EN
    assign out_col_idx    = out_col_idx_q;
`else
    logic unused_idx;
    assign unused_idx = ^out_col_idx_q;
`endif

endmodule

// File: tb/tb_shift_rows_col_feeder.sv
// Self-checking bench for shift_rows_col_feeder: directed FIPS-197 / stall /
// reset / back-to-back scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-based reference model.
module tb_shift_rows_col_feeder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         in_last_round = 1'b0;
    logic         out_stall = 1'b0;
    logic         out_col_valid;
    logic [31:0]  out_column;
    logic         out_col_last;
    logic         out_last_round;
`ifdef SHIFT_ROWS_COL_IDX_EN
    logic [1:0]   out_col_idx;
`endif

    shift_rows_col_feeder dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_state       (in_state),
        .in_last_round  (in_last_round),
        .out_stall      (out_stall),
        .out_col_valid  (out_col_valid),
        .out_column     (out_column),
        .out_col_last   (out_col_last),
`ifdef SHIFT_ROWS_COL_IDX_EN
        .out_col_idx    (out_col_idx),
`endif
        .out_last_round (out_last_round)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] col;
        logic [1:0]  idx;
        logic        lr;
    } col_t;

    col_t        mq[$];
    logic        exp_valid = 1'b0;
    logic [31:0] exp_col   = '0;
    logic        exp_last  = 1'b0;
    logic        exp_lr    = 1'b0;
    logic [1:0]  exp_idx   = '0;
    logic        accepted  = 1'b0;
    logic        mrdy;
    col_t        head;

    function automatic logic [7:0] byte_of(input logic [127:0] s, input int k);
        return s[127-8*k -: 8];
    endfunction

    // Output column c: row r comes from column (c + r) mod 4.
    function automatic logic [31:0] shift_col(input logic [127:0] s, input int c);
        logic [31:0] w;
        for (int r = 0; r < 4; r++) w[31-8*r -: 8] = byte_of(s, 4*((c + r) % 4) + r);
        return w;
    endfunction

    // Ready when nothing is pending, or the final pending column leaves now.
    function automatic logic model_ready();
        return (mq.size() == 0) || (mq.size() == 1 && !out_stall);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            exp_valid = 1'b0; exp_col = '0; exp_last = 1'b0;
            exp_lr = 1'b0; exp_idx = '0; accepted = 1'b0;
        end else begin
            cyc++;
            mrdy      = model_ready();
            accepted  = in_valid && mrdy;
            exp_valid = 1'b0;
            exp_last  = 1'b0;
            if (mq.size() > 0 && !out_stall) begin
                head      = mq.pop_front();
                exp_valid = 1'b1;
                exp_col   = head.col;
                exp_lr    = head.lr;
                exp_idx   = head.idx;
                exp_last  = (head.idx == 2'd3);
            end
            if (accepted)
                for (int c = 0; c < 4; c++)
                    mq.push_back('{col: shift_col(in_state, c), idx: 2'(c), lr: in_last_round});
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", 32'(in_ready), 32'(model_ready()));
            chk("out_col_valid", 32'(out_col_valid), 32'(exp_valid));
            chk("out_col_last", 32'(out_col_last), 32'(exp_last));
            chk("out_column", out_column, exp_col);
            chk("out_last_round", 32'(out_last_round), 32'(exp_lr));
`ifdef SHIFT_ROWS_COL_IDX_EN
            chk("out_col_idx", 32'(out_col_idx), 32'(exp_idx));
`endif
        end
    end

    // Capture of emitted columns for the literal checks.
    logic [31:0] cap_col[$];
    logic        cap_last[$];
    logic        cap_lr[$];
    int          cap_cyc[$];

    always @(negedge clk) begin
        if (!reset && out_col_valid) begin
            cap_col.push_back(out_column);
            cap_last.push_back(out_col_last);
            cap_lr.push_back(out_last_round);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic cap_clear();
        cap_col.delete(); cap_last.delete(); cap_lr.delete(); cap_cyc.delete();
    endtask

    // Present a state and wait (bounded) for it to be taken.
    task automatic send(input logic [127:0] s, input logic lr, input bit keep_valid);
        bit got = 0;
        in_valid = 1'b1; in_state = s; in_last_round = lr;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1; break; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready never seen, got 0 expected 1");
        end
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_cols(input int n);
        int i;
        for (i = 0; i < 60; i++) begin
            if (cap_col.size() >= n) break;
            @(negedge clk); #1;
        end
        if (cap_col.size() < n) begin
            checks++; errors++;
            $display("FAIL col_timeout: got %0d columns expected %0d", cap_col.size(), n);
        end
    endtask

    task automatic check_cols(input string name, input int base, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic lr);
        logic [31:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            if (cap_col.size() > base + i) begin
                chk({name, "_col"}, cap_col[base+i], e[i]);
                chk({name, "_last"}, 32'(cap_last[base+i]), 32'(i == 3));
                chk({name, "_lr"}, 32'(cap_lr[base+i]), 32'(lr));
            end
        end
    endtask

    localparam logic [127:0] FIPS = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_col_valid), 32'd0);
        chk("rst_column", out_column, 32'd0);
        chk("rst_last", 32'(out_col_last), 32'd0);
        chk("rst_lr", 32'(out_last_round), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // FIPS-197 round 1 ShiftRows.
        cap_clear();
        send(FIPS, 1'b0, 0);
        wait_cols(4);
        check_cols("fips", 0, 32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5, 1'b0);

        // Last-round flag with sequential bytes.
        repeat (3) @(posedge clk); #1;
        cap_clear();
        send(SEQ, 1'b1, 0);
        wait_cols(4);
        check_cols("seq", 0, 32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b, 1'b1);

        // Back-to-back: 8 consecutive columns.
        repeat (3) @(posedge clk); #1;
        cap_clear();
        send(FIPS, 1'b0, 1);
        send(SEQ, 1'b1, 0);
        wait_cols(8);
        check_cols("b2b_a", 0, 32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5, 1'b0);
        check_cols("b2b_b", 4, 32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b, 1'b1);
        if (cap_cyc.size() >= 8) chk("b2b_span", 32'(cap_cyc[7] - cap_cyc[0]), 32'd7);

        // Stall for 3 cycles after column 1.
        repeat (3) @(posedge clk); #1;
        cap_clear();
        send(FIPS, 1'b0, 0);
        wait_cols(2);
        out_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_stall = 1'b0;
        wait_cols(4);
        check_cols("stall", 0, 32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5, 1'b0);
        if (cap_cyc.size() >= 3) chk("stall_gap", 32'(cap_cyc[2] - cap_cyc[1]), 32'd4);

        // Reset after column 1 discards the partial state.
        repeat (3) @(posedge clk); #1;
        cap_clear();
        send(FIPS, 1'b1, 0);
        wait_cols(2);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_col_valid), 32'd0);
        chk("mid_rst_column", out_column, 32'd0);
        chk("mid_rst_last", 32'(out_col_last), 32'd0);
        chk("mid_rst_lr", 32'(out_last_round), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cap_clear();
        repeat (4) @(posedge clk); #1;
        chk("mid_rst_no_cols", 32'(cap_col.size()), 32'd0);
        send(SEQ, 1'b0, 0);
        wait_cols(4);
        check_cols("after_rst", 0, 32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            out_stall = ($urandom_range(0, 3) == 0);
            if (!in_valid || accepted) begin
                in_valid      = ($urandom_range(0, 2) != 0);
                in_state      = {$urandom, $urandom, $urandom, $urandom};
                in_last_round = $urandom_range(0, 1) == 1;
            end
        end
        in_valid = 1'b0; out_stall = 1'b0;
        repeat (10) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
